// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int ILEN_DEFAULT    = 32;
  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Holding register for the fetched instruction and its PC presented to decode.
module instr_fetch_unit_fetch_buffer #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [ILEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [ILEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [ILEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // Load wins over clear; clearing only drops valid so the payload stays put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: requests the instruction at pc_q, hands it to decode and
// steers the PC register with either PC+STEP or a redirect target.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int ILEN    = ILEN_DEFAULT,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_q,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic            w_pc_load;
  logic [XLEN-1:0] w_pc_next;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic            w_redirect;
  logic [XLEN-1:0] w_pc_inc;

  assign w_pc_inc   = pc_q + XLEN'(PC_STEP);
  assign w_redirect = redirect_valid && (r_state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_load    = 1'b0;
    w_pc_next    = '0;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_REQ;
      ST_REQ: begin
        if (w_redirect) begin
          w_state_next = imem_req_ready ? ST_DRAIN : ST_REQ;
        end else if (imem_req_ready) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_redirect) begin
          w_state_next = imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_rsp_valid) begin
          w_buf_load   = 1'b1;
          w_pc_load    = 1'b1;
          w_pc_next    = w_pc_inc;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_redirect || if_ready) begin
          w_buf_clear  = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      // A redirect here keeps draining unless the outstanding response is
      // arriving this very cycle, otherwise nothing would ever release us.
      ST_DRAIN: begin
        if (imem_rsp_valid) begin
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_redirect) begin
      w_pc_load   = 1'b1;
      w_pc_next   = redirect_pc;
      w_buf_clear = 1'b1;
    end
  end

  assign pc_load        = w_pc_load;
  assign pc_next        = w_pc_next;
  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = (r_state == ST_REQ) ? pc_q : '0;

  instr_fetch_unit_fetch_buffer #(
    .XLEN(XLEN),
    .ILEN(ILEN)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (imem_rsp_data),
    .i_pc    (pc_q),
    .o_valid (if_valid),
    .o_instr (if_instr),
    .o_pc    (if_pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small PC register model attached.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pcQ;
  logic [31:0] pcResetVal;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(.XLEN(32), .ILEN(32), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_q           (pcQ),
    .pc_load        (pc_load),
    .pc_next        (pc_next),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register the unit drives; its reset value is chosen per test.
  always @(posedge clk or negedge rst) begin
    if (!rst) pcQ <= pcResetVal;
    else if (pc_load) pcQ <= pc_next;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the negedge where reset released (IDLE).
  task automatic do_reset(input logic [31:0] startPc);
    @(negedge clk);
    pcResetVal = startPc;
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    pcResetVal = 32'h0;
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_if_valid: got %0b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_if_instr: got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_if_pc: got %h want 0", if_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL rst_pc_load: got %0b want 0", pc_load); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc_next: got %h want 0", pc_next); end
    do_reset(32'h0);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_req_valid: got %0b want 0", imem_req_valid); end
  endtask

  task automatic test_basic_fetch();
    do_reset(32'h0);
    tick(); imem_req_ready = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_req_valid: got %0b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL basic_req_addr: got %h want 0", imem_req_addr); end
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL basic_no_load_in_req: got %0b want 0", pc_load); end
    tick(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093; #1;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("[TB] FAIL basic_pc_load: got %0b want 1", pc_load); end
    checks++; if (pc_next !== 32'h4) begin errors++; $display("[TB] FAIL basic_pc_next: got %h want 4", pc_next); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %0b want 0", if_valid); end
    tick(); imem_rsp_valid = 1'b0; #1;
    checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL basic_load_once: got %0b want 0", pc_load); end
    checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_if_valid: got %0b want 1", if_valid); end
    checks++; if (if_instr !== 32'h00500093) begin errors++; $display("[TB] FAIL basic_if_instr: got %h want 00500093", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("[TB] FAIL basic_if_pc: got %h want 0", if_pc); end
    checks++; if (pcQ !== 32'h4) begin errors++; $display("[TB] FAIL basic_pc_reg: got %h want 4", pcQ); end
    if_ready = 1'b1;
    tick(); if_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_cleared: got %0b want 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin errors++; $display("[TB] FAIL basic_next_req: got valid %0b addr %h want 1 / 4", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_req_stall();
    do_reset(32'h40);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin errors++; $display("[TB] FAIL stall_req[%0d]: got valid %0b addr %h want 1 / 40", i, imem_req_valid, imem_req_addr); end
      checks++; if (pc_load !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_load[%0d]: got %0b want 0", i, pc_load); end
    end
    tick(); imem_req_ready = 1'b1; #1;
    checks++; if (imem_req_addr !== 32'h40) begin errors++; $display("[TB] FAIL stall_accept_addr: got %h want 40", imem_req_addr); end
    tick(); imem_req_ready = 1'b0; #1;
    checks++; if (pc_load !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_wait_idle: got load %0b req %0b want 0 / 0", pc_load, imem_req_valid); end
    tick(); imem_rsp_valid = 1'b1; imem_rsp_data = 32'h11111111; #1;
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h44) begin errors++; $display("[TB] FAIL stall_rsp_load: got load %0b next %h want 1 / 44", pc_load, pc_next); end
    tick(); imem_rsp_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin errors++; $display("[TB] FAIL stall_capture: got valid %0b pc %h want 1 / 40", if_valid, if_pc); end
  endtask

  task automatic test_hold_stall();
    do_reset(32'h200);
    tick(); imem_req_ready = 1'b1; #1;
    tick(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; #1;
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; #1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (if_valid !== 1'b1 || if_instr !== 32'hDEADBEEF || if_pc !== 32'h200) begin errors++; $display("[TB] FAIL hold_stable[%0d]: got %0b %h %h want 1 deadbeef 200", i, if_valid, if_instr, if_pc); end
      checks++; if (imem_req_valid !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("[TB] FAIL hold_quiet[%0d]: got req %0b load %0b want 0 / 0", i, imem_req_valid, pc_load); end
      tick(); #1;
    end
    if_ready = 1'b1; #1;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_handshake_valid: got %0b want 1", if_valid); end
    tick(); if_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204) begin errors++; $display("[TB] FAIL hold_resume: got valid %0b req %0b addr %h want 0 1 204", if_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset(32'h10);
    tick(); imem_req_ready = 1'b1; #1;
    tick(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h100) begin errors++; $display("[TB] FAIL redir_load: got load %0b next %h want 1 / 100", pc_load, pc_next); end
    tick(); redirect_valid = 1'b0; redirect_pc = 32'h0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BAD0BAD; #1;
    checks++; if (imem_req_valid !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("[TB] FAIL redir_drain: got req %0b load %0b want 0 / 0", imem_req_valid, pc_load); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drain_valid: got %0b want 0", if_valid); end
    tick(); imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_req_ready = 1'b1; #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_stale_valid: got %0b want 0", if_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_new_req: got valid %0b addr %h want 1 / 100", imem_req_valid, imem_req_addr); end
    tick(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000123; #1;
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h104) begin errors++; $display("[TB] FAIL redir_seq_next: got load %0b next %h want 1 / 104", pc_load, pc_next); end
    tick(); imem_rsp_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h123 || if_pc !== 32'h100) begin errors++; $display("[TB] FAIL redir_capture: got %0b %h %h want 1 123 100", if_valid, if_instr, if_pc); end
  endtask

  task automatic test_wrap();
    do_reset(32'hFFFFFFFC);
    tick(); imem_req_ready = 1'b1; #1;
    checks++; if (imem_req_addr !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", imem_req_addr); end
    tick(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFEF00D; #1;
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next: got load %0b next %h want 1 / 0", pc_load, pc_next); end
    tick(); imem_rsp_valid = 1'b0; if_ready = 1'b1; #1;
    checks++; if (if_pc !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_if_pc: got %h want fffffffc", if_pc); end
    tick(); if_ready = 1'b0; #1;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_req_zero: got %h want 0", imem_req_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset(32'h80);
    tick(); imem_req_ready = 1'b1; #1;
    tick(); imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55AA55AA; #1;
    checks++; if (pc_load !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_load: got %0b want 1", pc_load); end
    rst = 1'b0; #1;
    checks++; if (pc_load !== 1'b0 || pc_next !== 32'h0 || imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin errors++; $display("[TB] FAIL midrst_async: got load %0b next %h req %0b addr %h want all 0", pc_load, pc_next, imem_req_valid, imem_req_addr); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin errors++; $display("[TB] FAIL midrst_buffer: got %0b %h %h want 0 0 0", if_valid, if_instr, if_pc); end
    tick(); rst = 1'b1; #1;
    tick(); #1;
    checks++; if (if_valid !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stray_req: got valid %0b load %0b want 0 / 0", if_valid, pc_load); end
    tick(); imem_rsp_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin errors++; $display("[TB] FAIL midrst_recover: got valid %0b req %0b addr %h want 0 1 80", if_valid, imem_req_valid, imem_req_addr); end
  endtask

  initial begin
    rst = 1'b1;
    pcResetVal = 32'h0;
    clear_inputs();
    test_reset();
    test_basic_fetch();
    test_req_stall();
    test_hold_stall();
    test_redirect_wait();
    test_wrap();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
